// File: rtl/fusion_psum_accumulator.sv
//==============================================================================
// Module  : fusion_psum_accumulator
// Accumulates acc_len packed psums per lane and emits one result per group.
// Optional macro PSUM_SAT_EN: saturating lane adds with sticky out_ovf.
// Revision: 1.0
//==============================================================================
`default_nettype none

module fusion_psum_accumulator #(
    parameter int PSUM_W = 52,
    parameter int LANE_W = 13,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    input  logic [PSUM_W-1:0]    psum_data,
    input  logic                 lane_mode,
    input  logic                 signed_mode,
    input  logic [LEN_W-1:0]     acc_len,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   out_data,
    output logic                 out_ovf
);

    localparam int C_NLANES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [LEN_W-1:0]               count_q, count_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic                           mode_q, mode_d;
    logic                           sgn_q, sgn_d;
    logic [C_NLANES-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [C_NLANES-1:0][ACC_W-1:0] w_ext, w_sum;

    logic             w_accept, w_emit, w_first, w_mode, w_sgn;
    logic [LEN_W-1:0] w_len;
    logic [ACC_W-1:0] w_ext0;

`ifdef PSUM_SAT_EN
    logic [C_NLANES-1:0] w_sat;
    logic                ovf_q, ovf_d;
`endif

    assign psum_ready = ~rst & ((state_q != S_HOLD) | out_ready);
    assign w_accept   = psum_valid & psum_ready;
    assign w_emit     = (state_q == S_HOLD) & out_ready;
    // In HOLD an accept can only happen together with an emit, so it opens a new group.
    assign w_first    = w_accept & (state_q != S_ACCUM);
    assign w_mode     = w_first ? lane_mode : mode_q;
    assign w_sgn      = w_first ? signed_mode : sgn_q;
    assign w_len      = (acc_len == '0) ? LEN_W'(1) : acc_len;
    assign w_ext0     = w_sgn ? ACC_W'($signed(psum_data[31:0])) : ACC_W'(psum_data[31:0]);

    for (genvar gi = 0; gi < C_NLANES; gi++) begin : g_lane
        logic [LANE_W-1:0] w_raw;
        logic [ACC_W-1:0]  w_lane;
        logic [ACC_W-1:0]  w_lext;

        assign w_raw  = psum_data[gi*LANE_W +: LANE_W];
        assign w_lane = w_sgn ? ACC_W'($signed(w_raw)) : ACC_W'(w_raw);

        if (gi == 0) begin : g_l0
            assign w_lext = w_mode ? w_lane : w_ext0;
        end else begin : g_ln
            assign w_lext = w_mode ? w_lane : '0;
        end

        assign w_ext[gi] = w_lext;

`ifdef PSUM_SAT_EN
        logic [ACC_W:0]   w_full;
        logic             w_sovf, w_lsat;
        logic [ACC_W-1:0] w_slim;

        assign w_full = {1'b0, acc_q[gi]} + {1'b0, w_lext};
        // Signed overflow: operands agree in sign but the sum does not.
        assign w_sovf = (acc_q[gi][ACC_W-1] == w_lext[ACC_W-1]) &
                        (w_full[ACC_W-1] != acc_q[gi][ACC_W-1]);
        assign w_lsat = w_sgn ? w_sovf : w_full[ACC_W];
        assign w_slim = acc_q[gi][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
        assign w_sat[gi] = w_lsat;
        assign w_sum[gi] = !w_lsat ? w_full[ACC_W-1:0] : (w_sgn ? w_slim : {ACC_W{1'b1}});
`else
        assign w_sum[gi] = acc_q[gi] + w_lext;
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        mode_d  = mode_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        if (w_emit) begin
            state_d = S_IDLE;
        end
        if (w_first) begin
            mode_d  = lane_mode;
            sgn_d   = signed_mode;
            len_d   = w_len;
            acc_d   = w_ext;
            count_d = LEN_W'(1);
            state_d = (w_len == LEN_W'(1)) ? S_HOLD : S_ACCUM;
        end else if (w_accept) begin
            acc_d   = w_sum;
            count_d = count_q + LEN_W'(1);
            if (count_q == len_q - LEN_W'(1)) begin
                state_d = S_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
        end
    end

`ifdef PSUM_SAT_EN
    always_comb begin
        ovf_d = ovf_q;
        if (w_first) begin
            ovf_d = 1'b0;
        end else if (w_accept) begin
            ovf_d = ovf_q | (|w_sat);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_valid = (state_q == S_HOLD);
    assign out_data  = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_fusion_psum_accumulator.sv
//==============================================================================
// Module  : tb_fusion_psum_accumulator
// Directed plus random checks of fusion_psum_accumulator against a group-level model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_fusion_psum_accumulator;

    logic         clk = 1'b0;
    logic         rst;
    logic         psum_valid;
    logic         psum_ready;
    logic [51:0]  psum_data;
    logic         lane_mode;
    logic         signed_mode;
    logic [7:0]   acc_len;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_ovf;

    always #5 clk = ~clk;

    fusion_psum_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .psum_data   (psum_data),
        .lane_mode   (lane_mode),
        .signed_mode (signed_mode),
        .acc_len     (acc_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [127:0] d;
        logic         o;
    } res_t;

    res_t   exp_q[$];
    longint m_acc[4];
    int     m_cnt = 0;
    int     m_len = 1;
    logic   m_mode, m_sgn, m_ovf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [51:0] pack4(input logic [12:0] l3, input logic [12:0] l2,
                                          input logic [12:0] l1, input logic [12:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    // Numeric value of one lane of a psum word.
    function automatic longint lane_val(input logic [51:0] d, input int lane,
                                        input logic mode, input logic sgn);
        logic [12:0] v13;
        logic [31:0] v32;
        if (!mode) begin
            if (lane != 0) return 0;
            v32 = d[31:0];
            return (sgn && v32[31]) ? longint'(v32) - 64'sd4294967296 : longint'(v32);
        end
        v13 = d[lane*13 +: 13];
        return (sgn && v13[12]) ? longint'(v13) - 64'sd8192 : longint'(v13);
    endfunction

    function automatic longint lane_add(input longint a, input longint b,
                                        input logic sgn, output logic sat);
        longint s;
        s   = a + b;
        sat = 1'b0;
`ifdef PSUM_SAT_EN
        if (sgn) begin
            if (s > 64'sd2147483647) begin
                s = 64'sd2147483647; sat = 1'b1;
            end else if (s < -64'sd2147483648) begin
                s = -64'sd2147483648; sat = 1'b1;
            end
        end else if (s > 64'sd4294967295) begin
            s = 64'sd4294967295; sat = 1'b1;
        end
`else
        s = s & 64'sh0000_0000_FFFF_FFFF;
        if (sgn && s > 64'sd2147483647) s = s - 64'sd4294967296;
`endif
        return s;
    endfunction

    task automatic model_accept(input logic [51:0] d, input logic lm, input logic sm,
                                input logic [7:0] len);
        logic sat;
        res_t r;
        if (m_cnt == 0) begin
            m_mode = lm;
            m_sgn  = sm;
            m_len  = (len == 8'd0) ? 1 : int'(len);
            m_ovf  = 1'b0;
            for (int i = 0; i < 4; i++) m_acc[i] = lane_val(d, i, lm, sm);
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = lane_add(m_acc[i], lane_val(d, i, m_mode, m_sgn), m_sgn, sat);
                m_ovf    = m_ovf | sat;
            end
        end
        m_cnt++;
        if (m_cnt == m_len) begin
            r.d = '0;
            for (int i = 0; i < 4; i++) r.d[i*32 +: 32] = m_acc[i][31:0];
            r.o = m_ovf;
            exp_q.push_back(r);
            m_cnt = 0;
        end
    endtask

    // One clock: drive inputs, check outputs on the falling edge, advance the model.
    task automatic cycle(input logic pv, input logic [51:0] pd, input logic lm,
                         input logic sm, input logic [7:0] len, input logic ordy);
        logic acc, emit, pend;
        psum_valid  = pv;
        psum_data   = pd;
        lane_mode   = lm;
        signed_mode = sm;
        acc_len     = len;
        out_ready   = ordy;
        @(negedge clk);
        pend = (exp_q.size() > 0);
        chk1("out_valid", out_valid, pend);
        chk1("psum_ready", psum_ready, !(pend && !ordy));
        if (pend) begin
            chk("out_data", out_data, exp_q[0].d);
            chk1("out_ovf", out_ovf, exp_q[0].o);
        end
        acc  = pv && !(pend && !ordy);
        emit = pend && ordy;
        @(posedge clk);
        #1;
        if (emit) void'(exp_q.pop_front());
        if (acc) model_accept(pd, lm, sm, len);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        psum_valid = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        chk1("rst_psum_ready", psum_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 128'd0);
        chk1("rst_out_ovf", out_ovf, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        m_cnt = 0;
    endtask

    initial begin
        logic [51:0] rd;
        psum_data   = '0;
        lane_mode   = 1'b0;
        signed_mode = 1'b0;
        acc_len     = 8'd1;
        do_reset();

        // Four-lane unsigned, three psums per group.
        repeat (3) cycle(1'b1, pack4(13'd18, 13'd12, 13'd6, 13'd0), 1'b1, 1'b0, 8'd3, 1'b1);
        chk1("t1_valid", out_valid, 1'b1);
        chk("t1_result", out_data, {32'd54, 32'd36, 32'd18, 32'd0});
        cycle(1'b0, '0, 1'b0, 1'b0, 8'd1, 1'b1);

        // Single-lane signed.
        cycle(1'b1, 52'hFFFFC000, 1'b0, 1'b1, 8'd2, 1'b1);
        cycle(1'b1, 52'd100, 1'b0, 1'b1, 8'd2, 1'b1);
        chk("t2_result", out_data, {96'd0, 32'hFFFFC064});

        // Backpressure in HOLD, then emit and accept together.
        repeat (4) cycle(1'b1, 52'd55, 1'b0, 1'b0, 8'd2, 1'b0);
        chk("t3_stable", out_data, {96'd0, 32'hFFFFC064});
        cycle(1'b1, 52'd7, 1'b0, 1'b0, 8'd2, 1'b1);
        chk1("t3_valid_after", out_valid, 1'b0);
        cycle(1'b1, 52'd3, 1'b1, 1'b1, 8'd5, 1'b1);
        chk("t3_newgroup", out_data, 128'd10);
        cycle(1'b0, '0, 1'b0, 1'b0, 8'd1, 1'b1);

        // Reset mid-group, then a clean group.
        repeat (2) cycle(1'b1, pack4(13'd9, 13'd9, 13'd9, 13'd9), 1'b1, 1'b0, 8'd4, 1'b1);
        do_reset();
        repeat (4) cycle(1'b1, pack4(13'd1, 13'd1, 13'd1, 13'd1), 1'b1, 1'b0, 8'd4, 1'b1);
        chk("t4_result", out_data, {32'd4, 32'd4, 32'd4, 32'd4});
        cycle(1'b0, '0, 1'b0, 1'b0, 8'd1, 1'b1);

        // Unsigned overflow; upper psum bits must be ignored in single-lane mode.
        cycle(1'b1, 52'hABCDE_FFFFFFFF, 1'b0, 1'b0, 8'd2, 1'b1);
        cycle(1'b1, 52'd2, 1'b0, 1'b0, 8'd2, 1'b1);
`ifdef PSUM_SAT_EN
        chk("t5_result", out_data, {96'd0, 32'hFFFFFFFF});
        chk1("t5_ovf", out_ovf, 1'b1);
`else
        chk("t5_result", out_data, 128'd1);
        chk1("t5_ovf", out_ovf, 1'b0);
`endif
        cycle(1'b0, '0, 1'b0, 1'b0, 8'd1, 1'b1);

        // acc_len = 0 behaves as 1, back to back.
        cycle(1'b1, 52'd5, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("t6_first", out_data, 128'd5);
        cycle(1'b1, 52'd7, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("t6_second", out_data, 128'd7);
        cycle(1'b1, 52'd9, 1'b0, 1'b0, 8'd0, 1'b1);
        chk("t6_third", out_data, 128'd9);
        chk1("t6_ovf", out_ovf, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 8'd1, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                rd = {20'($urandom()), $urandom()};
                cycle(1'($urandom_range(0, 9) < 7), rd, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
                      1'($urandom_range(0, 9) < 7));
            end
        end
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, 8'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
